wb_pipe_chain: RTL and testbench



---
 rtl/wb_pipe_chain.sv | 160 ++++++++++++++++
 tb/tb_wb_pipe_chain.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_chain.sv
// Memory-to-writeback register chain with valid/ready handshake, bubble collapse and one-shot syn.
// Define WB_PIPE_FWD_EN to build the register-forwarding lookup (fwd_hit/fwd_data).
module wb_pipe_chain #(
   parameter int DEPTH = 2,
   parameter int INW   = 512,
   parameter int ADDRW = 32,
   parameter int IMMW  = 11,
   parameter int REGW  = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         fft_wr_en_in,
   input  logic                         reg_wr_en_in,
   input  logic                         syn_in,
   input  logic                         set_en_in,
   input  logic                         set_freq_in,
   input  logic [REGW-1:0]              wr_reg_in,
   input  logic [IMMW-1:0]              imm_in,
   input  logic [ADDRW-1:0]             addr_in,
   input  logic [INW-1:0]               data_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         fft_wr_en_out,
   output logic                         reg_wr_en_out,
   output logic                         syn_out,
   output logic                         set_en_out,
   output logic                         set_freq_out,
   output logic [REGW-1:0]              wr_reg_out,
   output logic [IMMW-1:0]              imm_out,
   output logic [ADDRW-1:0]             addr_out,
   output logic [INW-1:0]               data_out,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   input  logic [REGW-1:0]              fwd_reg,
   output logic                         fwd_hit,
   output logic [INW-1:0]               fwd_data
);

   localparam int OCCW = $clog2(DEPTH+1);

   typedef struct packed {
      logic             fft_wr_en;
      logic             reg_wr_en;
      logic             syn;
      logic             set_en;
      logic             set_freq;
      logic [REGW-1:0]  wr_reg;
      logic [IMMW-1:0]  imm;
      logic [ADDRW-1:0] addr;
      logic [INW-1:0]   data;
   } bundle_t;

   logic [DEPTH-1:0] v_q;
   bundle_t          stage_q [DEPTH];
   logic [OCCW-1:0]  occ_q;
   logic [OCCW-1:0]  occ_d;

   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] prev_v;
   bundle_t          prev_b [DEPTH];
   bundle_t          in_bundle;
   logic             in_fire;
   logic             out_fire;

   assign in_bundle = '{fft_wr_en: fft_wr_en_in, reg_wr_en: reg_wr_en_in, syn: syn_in,
                        set_en: set_en_in, set_freq: set_freq_in, wr_reg: wr_reg_in,
                        imm: imm_in, addr: addr_in, data: data_in};

   // A stage advances when it is empty or anything between it and the output moves.
   always_comb begin
      logic acc;
      acc = out_ready;
      adv = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         acc    = acc | ~v_q[k];
         adv[k] = acc;
      end
   end

   assign in_ready = adv[0] & ~flush;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = v_q[DEPTH-1] & out_ready;

   // Empty stages always hold an all-zero payload, so outputs read 0 whenever out_valid is low.
   always_comb begin
      prev_v    = '0;
      prev_v[0] = in_fire;
      prev_b[0] = in_fire ? in_bundle : '0;
      for (int k = 1; k < DEPTH; k++) begin
         prev_v[k] = v_q[k-1];
         prev_b[k] = stage_q[k-1];
      end
   end

   always_comb begin
      occ_d = occ_q;
      if (in_fire && !out_fire)
         occ_d = occ_q + OCCW'(1);
      else if (!in_fire && out_fire)
         occ_d = occ_q - OCCW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         occ_q <= '0;
         for (int k = 0; k < DEPTH; k++)
            stage_q[k] <= '0;
      end else if (flush) begin
         v_q   <= '0;
         occ_q <= '0;
         for (int k = 0; k < DEPTH; k++)
            stage_q[k] <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (adv[k]) begin
               v_q[k]     <= prev_v[k];
               stage_q[k] <= prev_b[k];
            end
         end
         if (v_q[DEPTH-1] && !out_ready)
            stage_q[DEPTH-1].syn <= 1'b0;
         occ_q <= occ_d;
      end
   end

   assign out_valid     = v_q[DEPTH-1];
   assign fft_wr_en_out = stage_q[DEPTH-1].fft_wr_en;
   assign reg_wr_en_out = stage_q[DEPTH-1].reg_wr_en;
   assign syn_out       = stage_q[DEPTH-1].syn;
   assign set_en_out    = stage_q[DEPTH-1].set_en;
   assign set_freq_out  = stage_q[DEPTH-1].set_freq;
   assign wr_reg_out    = stage_q[DEPTH-1].wr_reg;
   assign imm_out       = stage_q[DEPTH-1].imm;
   assign addr_out      = stage_q[DEPTH-1].addr;
   assign data_out      = stage_q[DEPTH-1].data;
   assign occupancy     = occ_q;

`ifdef WB_PIPE_FWD_EN
   // Scan oldest to youngest so the lowest-index match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         if (v_q[k] && stage_q[k].reg_wr_en && (stage_q[k].wr_reg == fwd_reg)) begin
            fwd_hit  = 1'b1;
            fwd_data = stage_q[k].data;
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^fwd_reg;
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_chain.sv
// Bench for wb_pipe_chain: directed scenarios plus random traffic against a queue-of-bundles model.
module tb_wb_pipe_chain;
   localparam int DEPTH = 2;
   localparam int INW   = 512;
   localparam int ADDRW = 32;
   localparam int IMMW  = 11;
   localparam int REGW  = 3;
   localparam int OCCW  = $clog2(DEPTH+1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             flush, in_valid, in_ready, out_valid, out_ready;
   logic             fft_wr_en_in, reg_wr_en_in, syn_in, set_en_in, set_freq_in;
   logic [REGW-1:0]  wr_reg_in, wr_reg_out, fwd_reg;
   logic [IMMW-1:0]  imm_in, imm_out;
   logic [ADDRW-1:0] addr_in, addr_out;
   logic [INW-1:0]   data_in, data_out, fwd_data;
   logic             fft_wr_en_out, reg_wr_en_out, syn_out, set_en_out, set_freq_out, fwd_hit;
   logic [OCCW-1:0]  occupancy;

   wb_pipe_chain #(.DEPTH(DEPTH), .INW(INW), .ADDRW(ADDRW), .IMMW(IMMW), .REGW(REGW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .fft_wr_en_in(fft_wr_en_in), .reg_wr_en_in(reg_wr_en_in), .syn_in(syn_in),
      .set_en_in(set_en_in), .set_freq_in(set_freq_in), .wr_reg_in(wr_reg_in),
      .imm_in(imm_in), .addr_in(addr_in), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .fft_wr_en_out(fft_wr_en_out), .reg_wr_en_out(reg_wr_en_out), .syn_out(syn_out),
      .set_en_out(set_en_out), .set_freq_out(set_freq_out), .wr_reg_out(wr_reg_out),
      .imm_out(imm_out), .addr_out(addr_out), .data_out(data_out),
      .occupancy(occupancy), .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   // Each in-flight bundle with its current stage position; oldest at the front.
   typedef struct {
      logic             fft, rw, syn, se, sf;
      logic [REGW-1:0]  wr;
      logic [IMMW-1:0]  imm;
      logic [ADDRW-1:0] addr;
      logic [INW-1:0]   data;
      int               pos;
   } ent_t;

   ent_t q[$];
   int   np[$];
   bit   head_leaves;
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic check_val(input string tag, input logic [INW-1:0] got, input logic [INW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [INW-1:0] rand_data();
      logic [INW-1:0] d;
      for (int i = 0; i < INW/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Work out where every bundle sits after the coming edge, and whether a new one fits.
   task automatic plan(output bit rdy);
      int prev_new;
      np.delete();
      head_leaves = 0;
      prev_new = DEPTH;
      foreach (q[i]) begin
         int p;
         p = q[i].pos;
         if (p == DEPTH-1) begin
            if (out_ready) begin head_leaves = 1; np.push_back(-1); prev_new = DEPTH; end
            else begin np.push_back(p); prev_new = p; end
         end else if (prev_new > p+1) begin
            np.push_back(p+1); prev_new = p+1;
         end else begin
            np.push_back(p); prev_new = p;
         end
      end
      rdy = !flush && (prev_new > 0);
   endtask

   task automatic commit(input bit rdy);
      ent_t e;
      if (flush) begin q.delete(); return; end
      foreach (q[i]) begin
         if (q[i].pos == DEPTH-1 && np[i] == DEPTH-1) q[i].syn = 1'b0;
         if (np[i] >= 0) q[i].pos = np[i];
      end
      if (head_leaves) void'(q.pop_front());
      if (in_valid && rdy) begin
         e.fft = fft_wr_en_in; e.rw = reg_wr_en_in; e.syn = syn_in; e.se = set_en_in;
         e.sf = set_freq_in; e.wr = wr_reg_in; e.imm = imm_in; e.addr = addr_in;
         e.data = data_in; e.pos = 0;
         q.push_back(e);
      end
   endtask

   task automatic check_outputs();
      ent_t e;
      bit   ov;
      e = '{fft: 0, rw: 0, syn: 0, se: 0, sf: 0, wr: '0, imm: '0, addr: '0, data: '0, pos: 0};
      ov = (q.size() > 0) && (q[0].pos == DEPTH-1);
      if (ov) e = q[0];
      check_val("out_valid", INW'(out_valid), INW'(ov));
      check_val("occupancy", INW'(occupancy), INW'(q.size()));
      check_val("data_out", data_out, e.data);
      check_val("syn_out", INW'(syn_out), INW'(e.syn));
      check_val("ctrl_out", INW'({fft_wr_en_out, reg_wr_en_out, set_en_out, set_freq_out}),
                INW'({e.fft, e.rw, e.se, e.sf}));
      check_val("wr_reg_out", INW'(wr_reg_out), INW'(e.wr));
      check_val("imm_out", INW'(imm_out), INW'(e.imm));
      check_val("addr_out", INW'(addr_out), INW'(e.addr));
   endtask

   task automatic check_fwd();
      bit             hit;
      logic [INW-1:0] d;
      hit = 0;
      d = '0;
`ifdef WB_PIPE_FWD_EN
      foreach (q[i]) if (q[i].rw && q[i].wr == fwd_reg) begin hit = 1; d = q[i].data; end
`endif
      check_val("fwd_hit", INW'(fwd_hit), INW'(hit));
      check_val("fwd_data", fwd_data, d);
   endtask

   // Inputs are already applied; check combinational outputs, clock, update model, check registers.
   task automatic step();
      bit rdy;
      plan(rdy);
      #1;
      check_val("in_ready", INW'(in_ready), INW'(rdy));
      check_fwd();
      @(posedge clk);
      commit(rdy);
      #1;
      check_outputs();
   endtask

   task automatic set_in(input bit v, input logic [INW-1:0] d, input bit syn,
                         input bit rw, input logic [REGW-1:0] wr);
      in_valid = v; data_in = d; syn_in = syn; reg_wr_en_in = rw; wr_reg_in = wr;
      fft_wr_en_in = 0; set_en_in = 0; set_freq_in = 0; imm_in = '0; addr_in = '0;
   endtask

   task automatic rand_in();
      in_valid = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      flush = ($urandom_range(24) == 0);
      fft_wr_en_in = $urandom; reg_wr_en_in = $urandom; syn_in = $urandom;
      set_en_in = $urandom; set_freq_in = $urandom;
      wr_reg_in = REGW'($urandom); fwd_reg = REGW'($urandom);
      imm_in = IMMW'($urandom); addr_in = $urandom; data_in = rand_data();
   endtask

   initial begin
      flush = 0; out_ready = 0; fwd_reg = '0;
      set_in(0, '0, 0, 0, '0);
      #12;
      check_outputs();
      rst_n = 1'b1;

      // Streaming with out_ready held high
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin set_in(1, INW'(i), 0, 0, '0); step(); end
      set_in(0, '0, 0, 0, '0);
      for (int i = 0; i < 3; i++) step();

      // Backpressure: fill with A,B, hold, then drain
      out_ready = 0;
      set_in(1, INW'(32'hA), 0, 0, '0); step();
      set_in(1, INW'(32'hB), 0, 0, '0); step();
      set_in(1, INW'(32'hC), 0, 0, '0);
      for (int i = 0; i < 3; i++) step();
      out_ready = 1; set_in(0, '0, 0, 0, '0);
      for (int i = 0; i < 3; i++) step();

      // Bubble collapse: output stage stalled, stage 0 empty, push accepted
      out_ready = 0;
      set_in(1, INW'(32'hD), 0, 0, '0); step();
      set_in(0, '0, 0, 0, '0); step();
      set_in(1, INW'(32'hC0), 0, 0, '0); step();

      // syn one-shot under backpressure
      out_ready = 1; set_in(0, '0, 0, 0, '0);
      for (int i = 0; i < 3; i++) step();
      out_ready = 0;
      set_in(1, INW'(32'h5), 1, 0, '0); step();
      set_in(0, '0, 0, 0, '0);
      for (int i = 0; i < 5; i++) step();
      out_ready = 1;
      for (int i = 0; i < 2; i++) step();

      // Flush with a bundle offered
      out_ready = 0;
      set_in(1, INW'(32'h11), 0, 0, '0); step();
      set_in(1, INW'(32'h22), 0, 0, '0); step();
      flush = 1; set_in(1, INW'(32'h33), 0, 0, '0); step();
      flush = 0; out_ready = 1; set_in(0, '0, 0, 0, '0);
      for (int i = 0; i < 3; i++) step();

      // Forwarding lookup: older write 0xBB, younger 0xAA to the same register
      out_ready = 0;
      set_in(1, INW'(32'hBB), 0, 1, REGW'(5)); step();
      set_in(1, INW'(32'hAA), 0, 1, REGW'(5)); step();
      set_in(0, '0, 0, 0, '0);
      fwd_reg = REGW'(5); step();
      fwd_reg = REGW'(3); step();
      out_ready = 1;
      for (int i = 0; i < 3; i++) step();

      for (int i = 0; i < 400; i++) begin rand_in(); step(); end

      // Asynchronous reset mid-transfer drops everything
      flush = 0; out_ready = 0;
      set_in(1, INW'(32'h77), 0, 0, '0); step(); step();
      rst_n = 1'b0;
      #1;
      q.delete();
      check_outputs();
      #1 rst_n = 1'b1;
      set_in(0, '0, 0, 0, '0); out_ready = 1;
      step();
      for (int i = 0; i < 100; i++) begin rand_in(); step(); end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
